// File: rtl/rgmii_tx_fmt_pkg.sv
// rgmii_tx_fmt_pkg: shared state encoding, speed constants and default IFG for the RGMII transmit formatter.
package rgmii_tx_fmt_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BYTE   = 3'd1,
        NIB_LO = 3'd2,
        NIB_HI = 3'd3,
        GAP    = 3'd4
    } state_e;

    localparam logic SPEED_100M  = 1'b0;
    localparam logic SPEED_1000M = 1'b1;
    localparam int   IFG_MIN_DEF = 12;
endpackage

// File: rtl/rgmii_tx_ifg_cnt.sv
// rgmii_tx_ifg_cnt: loadable down-counter that stops at zero and flags done while at zero.
module rgmii_tx_ifg_cnt #(
    parameter int W = 4
) (
    input  logic         user_clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/rgmii_tx_fmt.sv
// rgmii_tx_fmt: GMII byte stream to per-cycle RGMII rising/falling nibbles and TX_CTL for external ODDRs.
// Define RGMII_TX_STATS_EN to add saturating frame/byte/error counters.
module rgmii_tx_fmt
    import rgmii_tx_fmt_pkg::*;
#(
    parameter int IFG_MIN = IFG_MIN_DEF
`ifdef RGMII_TX_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       user_clk,
    input  logic       reset_n,
    input  logic       speed,
    input  logic [7:0] txd,
    input  logic       txen,
    input  logic       txer,
    output logic       tx_ready,
    output logic [3:0] rgmii_txd_r,
    output logic [3:0] rgmii_txd_f,
    output logic       rgmii_txctl_r,
    output logic       rgmii_txctl_f,
    output logic       busy
`ifdef RGMII_TX_STATS_EN
    ,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);
    localparam int     IFG_W  = (IFG_MIN > 1) ? $clog2(IFG_MIN) : 1;
    localparam state_e END_ST = (IFG_MIN == 0) ? IDLE : GAP;

    state_e     state_q, state_d;
    logic       mode_q, mode_d, er_q, er_d, acc, ifg_done;
    logic [7:0] byte_q, byte_d;
    logic [3:0] txd_r_q, txd_r_d, txd_f_q, txd_f_d;
    logic       ready_q, ready_d, busy_q, busy_d, ctl_r_q, ctl_r_d, ctl_f_q, ctl_f_d;

    assign acc = txen && ready_q;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            er_q    <= 1'b0;
            byte_q  <= '0;
            txd_r_q <= '0;
            txd_f_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ctl_r_q <= 1'b0;
            ctl_f_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            er_q    <= er_d;
            byte_q  <= byte_d;
            txd_r_q <= txd_r_d;
            txd_f_q <= txd_f_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            ctl_r_q <= ctl_r_d;
            ctl_f_q <= ctl_f_d;
        end
    end

    always_comb begin
        mode_d  = (state_q == IDLE && acc) ? speed : mode_q;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = acc ? ((mode_d == SPEED_1000M) ? BYTE : NIB_LO) : IDLE;
            BYTE:    state_d = acc ? BYTE : END_ST;
            NIB_LO:  state_d = NIB_HI;
            NIB_HI:  state_d = acc ? NIB_LO : END_ST;
            GAP:     state_d = ifg_done ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are computed from the next state so they line up with state_q.
    always_comb begin
        byte_d  = acc ? txd : byte_q;
        er_d    = acc ? txer : er_q;
        ready_d = (state_d == IDLE) || (state_d == BYTE) || (state_d == NIB_HI);
        busy_d  = (state_d != IDLE);
        ctl_r_d = (state_d == BYTE) || (state_d == NIB_LO) || (state_d == NIB_HI);
        ctl_f_d = ctl_r_d && !er_d;
        txd_r_d = (state_d == BYTE || state_d == NIB_LO) ? byte_d[3:0] :
                  (state_d == NIB_HI) ? byte_d[7:4] : 4'h0;
        txd_f_d = (state_d == BYTE) ? byte_d[7:4] : txd_r_d;
    end

    rgmii_tx_ifg_cnt #(.W(IFG_W)) u_ifg (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .load     (state_d == GAP && state_q != GAP),
        .load_val (IFG_W'(IFG_MIN - 1)),
        .dec      (state_q == GAP),
        .done     (ifg_done)
    );

    assign tx_ready      = ready_q;
    assign busy          = busy_q;
    assign rgmii_txd_r   = txd_r_q;
    assign rgmii_txd_f   = txd_f_q;
    assign rgmii_txctl_r = ctl_r_q;
    assign rgmii_txctl_f = ctl_f_q;

`ifdef RGMII_TX_STATS_EN
    logic [CNT_W-1:0] frame_q, frame_d, bytes_q, bytes_d, errs_q, errs_d;
    logic             err_seen_q, err_seen_d, start;

    assign start = acc && (state_q == IDLE);

    // err_seen limits the error counter to one increment per frame.
    always_comb begin
        err_seen_d = start ? txer : (err_seen_q || (acc && txer));
        frame_d    = (start && !(&frame_q)) ? frame_q + CNT_W'(1) : frame_q;
        bytes_d    = (acc && !(&bytes_q)) ? bytes_q + CNT_W'(1) : bytes_q;
        errs_d     = (acc && txer && (start || !err_seen_q) && !(&errs_q)) ? errs_q + CNT_W'(1) : errs_q;
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_seen_q <= 1'b0;
            frame_q    <= '0;
            bytes_q    <= '0;
            errs_q     <= '0;
        end else begin
            err_seen_q <= err_seen_d;
            frame_q    <= frame_d;
            bytes_q    <= bytes_d;
            errs_q     <= errs_d;
        end
    end

    assign frame_cnt = frame_q;
    assign byte_cnt  = bytes_q;
    assign err_cnt   = errs_q;
`endif
endmodule

// File: tb/tb_rgmii_tx_fmt.sv
// tb_rgmii_tx_fmt: directed scoreboard bench for rgmii_tx_fmt (stats checks when RGMII_TX_STATS_EN is defined).
module tb_rgmii_tx_fmt;
    import rgmii_tx_fmt_pkg::*;

    logic       user_clk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       speed    = SPEED_1000M;
    logic       txen     = 1'b0;
    logic       txer     = 1'b0;
    logic [7:0] txd      = 8'h00;
    logic       tx_ready, rgmii_txctl_r, rgmii_txctl_f, busy;
    logic [3:0] rgmii_txd_r, rgmii_txd_f;
    logic [9:0] sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;
`ifdef RGMII_TX_STATS_EN
    logic [31:0] frame_cnt, byte_cnt, err_cnt;
    logic        s_ready, s_ctl_r, s_ctl_f, s_busy;
    logic [3:0]  s_txd_r, s_txd_f, s_frames, s_bytes, s_errs;
`endif

    always #4 user_clk = ~user_clk;

    rgmii_tx_fmt #(.IFG_MIN(12)) dut (
        .user_clk      (user_clk),
        .reset_n       (reset_n),
        .speed         (speed),
        .txd           (txd),
        .txen          (txen),
        .txer          (txer),
        .tx_ready      (tx_ready),
        .rgmii_txd_r   (rgmii_txd_r),
        .rgmii_txd_f   (rgmii_txd_f),
        .rgmii_txctl_r (rgmii_txctl_r),
        .rgmii_txctl_f (rgmii_txctl_f),
        .busy          (busy)
`ifdef RGMII_TX_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .byte_cnt      (byte_cnt),
        .err_cnt       (err_cnt)
`endif
    );

`ifdef RGMII_TX_STATS_EN
    rgmii_tx_fmt #(.IFG_MIN(12), .CNT_W(4)) dut_sat (
        .user_clk      (user_clk),
        .reset_n       (reset_n),
        .speed         (speed),
        .txd           (txd),
        .txen          (txen),
        .txer          (txer),
        .tx_ready      (s_ready),
        .rgmii_txd_r   (s_txd_r),
        .rgmii_txd_f   (s_txd_f),
        .rgmii_txctl_r (s_ctl_r),
        .rgmii_txctl_f (s_ctl_f),
        .busy          (s_busy),
        .frame_cnt     (s_frames),
        .byte_cnt      (s_bytes),
        .err_cnt       (s_errs)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one byte, hold until accepted, and queue the output cycles it must produce.
    task automatic put(input logic [7:0] b, input logic er, input logic nib, output int w);
        txen = 1'b1;
        txd  = b;
        txer = er;
        w    = 0;
        while (tx_ready !== 1'b1 && w < 20) begin
            @(negedge user_clk);
            w++;
        end
        if (w == 20) chk("ready_timeout", {31'd0, tx_ready}, 32'd1);
        if (nib) begin
            sb.push_back({b[3:0], b[3:0], 1'b1, ~er});
            sb.push_back({b[7:4], b[7:4], 1'b1, ~er});
        end else begin
            sb.push_back({b[3:0], b[7:4], 1'b1, ~er});
        end
        @(negedge user_clk);
    endtask

    task automatic end_frame();
        txen = 1'b0;
        txer = 1'b0;
        @(negedge user_clk);
    endtask

    // Count tx_ready-low cycles until the block is back in IDLE.
    task automatic gap(output int g);
        int n = 0;
        g = 0;
        while (busy === 1'b1 && n < 60) begin
            if (tx_ready === 1'b0) g++;
            @(negedge user_clk);
            n++;
        end
        if (n == 60) chk("idle_timeout", {31'd0, busy}, 32'd0);
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    always @(negedge user_clk) begin
        if (rgmii_txctl_r !== 1'b1)
            chk("idle_out", {23'd0, rgmii_txd_r, rgmii_txd_f, rgmii_txctl_f}, 32'd0);
        else if (sb.size() == 0)
            chk("sb_extra", {22'd0, rgmii_txd_r, rgmii_txd_f, rgmii_txctl_r, rgmii_txctl_f}, 32'd0);
        else
            chk("sb_data", {22'd0, rgmii_txd_r, rgmii_txd_f, rgmii_txctl_r, rgmii_txctl_f}, {22'd0, sb.pop_front()});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, g;
        repeat (3) @(negedge user_clk);
        chk("reset_outs", {20'd0, tx_ready, busy, rgmii_txd_r, rgmii_txd_f, rgmii_txctl_r, rgmii_txctl_f}, 32'd0);
        reset_n = 1'b1;
        @(negedge user_clk);
        chk("ready_after_reset", {31'd0, tx_ready}, 32'd1);
        chk("busy_after_reset", {31'd0, busy}, 32'd0);

        speed = SPEED_1000M;
        for (int i = 0; i < 64; i++) begin
            put(8'(i), 1'b0, 1'b0, w);
            if (i == 1) chk("busy_in_frame", {31'd0, busy}, 32'd1);
            if (i == 8'h3A)
                chk("lat_3a", {22'd0, rgmii_txd_r, rgmii_txd_f, rgmii_txctl_r, rgmii_txctl_f}, {22'd0, 4'hA, 4'h3, 1'b1, 1'b1});
        end
        end_frame();
        gap(g);
        chk("ifg_1000", g, 32'd12);

        speed = SPEED_100M;
        put(8'h55, 1'b0, 1'b1, w);
        chk("nib_ready_lo0", {31'd0, tx_ready}, 32'd0);
        put(8'hD5, 1'b0, 1'b1, w);
        chk("nib_pulse1", w, 32'd1);
        chk("nib_ready_lo1", {31'd0, tx_ready}, 32'd0);
        put(8'hA7, 1'b0, 1'b1, w);
        chk("nib_pulse2", w, 32'd1);
        end_frame();
        gap(g);
        chk("ifg_100", g, 32'd12);

        speed = SPEED_1000M;
        for (int i = 0; i < 16; i++) begin
            put(8'(i * 7), i == 10, 1'b0, w);
            if (i == 10) chk("txer_ctl", {30'd0, rgmii_txctl_r, rgmii_txctl_f}, 32'd2);
        end
        end_frame();
        gap(g);

        for (int i = 0; i < 8; i++) begin
            put(8'(8'h80 + i), 1'b0, 1'b0, w);
            if (i == 2) speed = SPEED_100M;
        end
        end_frame();
        gap(g);
        for (int i = 0; i < 3; i++) begin
            put(8'(8'hC1 + i * 16), 1'b0, 1'b1, w);
            if (i > 0) chk("speed_nib_pulse", w, 32'd1);
        end
        end_frame();
        gap(g);

        put(8'h3C, 1'b0, 1'b1, w);
        #2 reset_n = 1'b0;
        #1 chk("reset_mid", {20'd0, tx_ready, busy, rgmii_txd_r, rgmii_txd_f, rgmii_txctl_r, rgmii_txctl_f}, 32'd0);
        sb.delete();
        txen = 1'b0;
        repeat (2) @(negedge user_clk);
        reset_n = 1'b1;
        @(negedge user_clk);
        chk("ready_post_rst", {31'd0, tx_ready}, 32'd1);
        chk("idle_post_rst", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge user_clk);

`ifdef RGMII_TX_STATS_EN
        speed = SPEED_1000M;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 10; i++) put(8'(f * 10 + i), f == 1 && (i == 3 || i == 6), 1'b0, w);
            end_frame();
            gap(g);
        end
        chk("frame_cnt", frame_cnt, 32'd3);
        chk("byte_cnt", byte_cnt, 32'd30);
        chk("err_cnt", err_cnt, 32'd1);
        chk("sat_frame", {28'd0, s_frames}, 32'd3);
        chk("sat_byte", {28'd0, s_bytes}, 32'd15);
        chk("sat_err", {28'd0, s_errs}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
